// File: rtl/scff_chain_bist_ctrl_if.sv
// Control/status and scan-fabric bundle for the scan-chain BIST controller.
// master: test host + fabric (drives start/config/tails); slave: the controller.
interface scff_chain_bist_ctrl_if #(
  parameter int NUM_CHAINS = 4,
  parameter int LEN_W      = 9,
  parameter int ERR_W      = 8
);
  logic                  start;
  logic [LEN_W-1:0]      chain_len;
  logic                  mode_prbs;
  logic [NUM_CHAINS-1:0] sc_tail;
  logic [NUM_CHAINS-1:0] sc_head;
  logic                  test_en;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic                  cfg_err;
  logic [NUM_CHAINS-1:0] err_mask;
  logic [ERR_W-1:0]      err_count;

  modport master (
    output start, chain_len, mode_prbs, sc_tail,
    input  sc_head, test_en, busy, done,
    input  pass, cfg_err, err_mask, err_count
  );

  modport slave (
    input  start, chain_len, mode_prbs, sc_tail,
    output sc_head, test_en, busy, done,
    output pass, cfg_err, err_mask, err_count
  );
endinterface

// File: rtl/scff_chain_bist_ctrl.sv
// Scan-chain BIST: flush N chains, inject pulse/PRBS-7 at sc_head, check sc_tail.
// Ports: op_clk, Reset (async, active-low), bus (slave). PRBS: SCFF_BIST_PRBS_EN.
module scff_chain_bist_ctrl #(
  parameter int NUM_CHAINS = 4,
  parameter int CHAIN_LEN  = 256,
  parameter int LEN_W      = 9,
  parameter int CHECK_TAIL = 2,
  parameter int ERR_W      = 8
) (
  input logic                  op_clk,
  input logic                  Reset,
  scff_chain_bist_ctrl_if.slave bus
);

  localparam int CNT_W = LEN_W + 1;
  localparam logic [CNT_W-1:0] MAX_L = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] TAIL  = CNT_W'(CHECK_TAIL);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    SHIFT,
    DONE
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [LEN_W-1:0]      len_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [NUM_CHAINS-1:0] head_q;
  logic [NUM_CHAINS-1:0] mask_q;
  logic [ERR_W-1:0]      errc_q;
  logic                  cfg_q;
  logic                  ran_q;

  logic [CNT_W-1:0]      len_ext;
  logic                  len_ok;
  logic                  accept;
  logic                  in_shift;
  logic                  last_flush;
  logic                  last_shift;
  logic                  exp_bit;
  logic                  head_bit_d;
  logic [NUM_CHAINS-1:0] mism;

  assign len_ext    = {1'b0, len_q};
  assign len_ok     = (bus.chain_len != '0) &&
                      ({1'b0, bus.chain_len} <= MAX_L);
  assign accept     = (state_q == IDLE) && bus.start;
  assign in_shift   = (state_q == SHIFT);
  assign last_flush = (cnt_q == len_ext - 1'b1);
  assign last_shift = (cnt_q == len_ext + TAIL);

  // State register
  always_ff @(posedge op_clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = len_ok ? FLUSH : DONE;
      end
      FLUSH: begin
        if (last_flush) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_shift) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    bus.busy    = (state_q == FLUSH) || (state_q == SHIFT);
    bus.test_en = bus.busy;
    bus.done    = (state_q == DONE);
    bus.pass    = ran_q && (mask_q == '0) && !cfg_q;
  end

  assign bus.sc_head   = head_q;
  assign bus.cfg_err   = cfg_q;
  assign bus.err_mask  = mask_q;
  assign bus.err_count = errc_q;

  // Cycle index within FLUSH/SHIFT; restarts at 0 on each state change.
  always_comb begin
    cnt_d = '0;
    if (bus.busy && (state_d == state_q)) cnt_d = cnt_q + 1'b1;
  end

`ifdef SCFF_BIST_PRBS_EN
  // gen_q drives the head; chk_q is an identical LFSR started L cycles
  // later so it lines up with what a length-L chain returns.
  logic       prbs_q;
  logic [6:0] gen_q;
  logic [6:0] chk_q;

  function automatic logic [6:0] lfsr_step(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  always_ff @(posedge op_clk or negedge Reset) begin
    if (!Reset) begin
      prbs_q <= 1'b0;
      gen_q  <= '0;
      chk_q  <= '0;
    end else if (accept) begin
      prbs_q <= bus.mode_prbs;
      gen_q  <= 7'h01;
      chk_q  <= 7'h01;
    end else begin
      if (state_d == SHIFT) gen_q <= lfsr_step(gen_q);
      if (in_shift && (cnt_q >= len_ext)) chk_q <= lfsr_step(chk_q);
    end
  end

  always_comb begin
    if (prbs_q) begin
      exp_bit    = (cnt_q >= len_ext) && chk_q[6];
      head_bit_d = (state_d == SHIFT) && gen_q[6];
    end else begin
      exp_bit    = (cnt_q == len_ext);
      head_bit_d = (state_d == SHIFT) && (cnt_d == '0);
    end
  end
`else
  assign exp_bit    = (cnt_q == len_ext);
  assign head_bit_d = (state_d == SHIFT) && (cnt_d == '0);
`endif

  // X/Z on a tail counts as a mismatch.
  always_comb begin
    mism = '0;
    for (int i = 0; i < NUM_CHAINS; i++) begin
      mism[i] = in_shift && (bus.sc_tail[i] !== exp_bit);
    end
  end

  // Datapath and result registers
  always_ff @(posedge op_clk or negedge Reset) begin
    if (!Reset) begin
      len_q  <= '0;
      cnt_q  <= '0;
      head_q <= '0;
      mask_q <= '0;
      errc_q <= '0;
      cfg_q  <= 1'b0;
      ran_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= {NUM_CHAINS{head_bit_d}};
      if (accept) begin
        len_q  <= bus.chain_len;
        mask_q <= '0;
        errc_q <= '0;
        cfg_q  <= !len_ok;
        ran_q  <= (state_d == DONE);
      end else begin
        mask_q <= mask_q | mism;
        if ((mism != '0) && (errc_q != {ERR_W{1'b1}})) begin
          errc_q <= errc_q + 1'b1;
        end
        if (state_d == DONE) ran_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scff_chain_bist_ctrl.sv
// Directed bench for scff_chain_bist_ctrl with a shift-register fabric model.
// Chains: per-chain length, stuck-at-1 and single-cycle tail flip injection.
module tb_scff_chain_bist_ctrl;

  localparam int NC = 4;
  localparam int CL = 256;
  localparam int LW = 9;
  localparam int CT = 2;
  localparam int EW = 8;

  logic op_clk = 1'b0;
  logic Reset  = 1'b0;
  always #5 op_clk = ~op_clk;

  scff_chain_bist_ctrl_if #(
    .NUM_CHAINS(NC), .LEN_W(LW), .ERR_W(EW)
  ) bus ();

  scff_chain_bist_ctrl #(
    .NUM_CHAINS(NC), .CHAIN_LEN(CL), .LEN_W(LW),
    .CHECK_TAIL(CT), .ERR_W(EW)
  ) dut (
    .op_clk(op_clk),
    .Reset (Reset),
    .bus   (bus)
  );

  logic [CL-1:0] sr [NC];
  int            flen [NC];
  logic [NC-1:0] stuck;
  logic [NC-1:0] flip;

  always @(posedge op_clk) begin
    if (bus.test_en) begin
      for (int i = 0; i < NC; i++) begin
        sr[i] <= {sr[i][CL-2:0], bus.sc_head[i]};
      end
    end
  end

  always_comb begin
    bus.sc_tail = '0;
    for (int i = 0; i < NC; i++) begin
      bus.sc_tail[i] = (sr[i][flen[i]-1] | stuck[i]) ^ flip[i];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic set_len(input int l);
    for (int i = 0; i < NC; i++) flen[i] = l;
  endtask

  // n = negedges from start to done (-1 on timeout), te = test_en cycles.
  task automatic run(input int L, input int flip_k,
                     input int glitch_n, input int abort_n,
                     output int n, output int te);
    n  = 0;
    te = 0;
    @(negedge op_clk);
    bus.chain_len = L[LW-1:0];
    bus.start     = 1'b1;
    forever begin
      @(negedge op_clk);
      n++;
      bus.start = 1'b0;
      flip      = '0;
      if (n == glitch_n) begin
        bus.start     = 1'b1;
        bus.chain_len = 9'd5;
      end
      if (n - L - 1 == flip_k) flip = 4'b0001;
      if (n == abort_n) return;
      if (bus.test_en) te++;
      if (bus.done) break;
      if (n > 2000) begin
        n = -1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.busy !== 1'b0 || bus.test_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got %b/%b want 0/0",
               bus.busy, bus.test_en);
    end
    checks++;
    if (bus.done !== 1'b0 || bus.pass !== 1'b0) begin
      errors++;
      $display("FAIL rst_done got %b/%b want 0/0",
               bus.done, bus.pass);
    end
    checks++;
    if (bus.cfg_err !== 1'b0 || bus.sc_head !== 4'b0) begin
      errors++;
      $display("FAIL rst_cfg got %b/%b want 0/0",
               bus.cfg_err, bus.sc_head);
    end
    checks++;
    if (bus.err_mask !== 4'b0 || bus.err_count !== 8'd0) begin
      errors++;
      $display("FAIL rst_err got %b/%0d want 0/0",
               bus.err_mask, bus.err_count);
    end
  endtask

  task automatic test_pulse_pass();
    int n, te;
    set_len(16);
    run(16, -100, -1, -1, n, te);
    checks++;
    if (n !== 36) begin
      errors++;
      $display("FAIL pass_lat got %0d want 36", n);
    end
    checks++;
    if (te !== 35) begin
      errors++;
      $display("FAIL pass_te got %0d want 35", te);
    end
    checks++;
    if (bus.pass !== 1'b1 || bus.cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL pass_flag got %b/%b want 1/0",
               bus.pass, bus.cfg_err);
    end
    checks++;
    if (bus.err_mask !== 4'b0 || bus.err_count !== 8'd0) begin
      errors++;
      $display("FAIL pass_err got %b/%0d want 0/0",
               bus.err_mask, bus.err_count);
    end
    @(negedge op_clk);
    checks++;
    if (bus.done !== 1'b0 || bus.pass !== 1'b1) begin
      errors++;
      $display("FAIL pass_hold got done %b pass %b want 0/1",
               bus.done, bus.pass);
    end
  endtask

  task automatic test_short_chain();
    int n, te;
    set_len(16);
    flen[2] = 15;
    run(16, -100, -1, -1, n, te);
    checks++;
    if (bus.err_mask !== 4'b0100) begin
      errors++;
      $display("FAIL short_mask got %b want 0100", bus.err_mask);
    end
    checks++;
    if (bus.err_count !== 8'd2 || bus.pass !== 1'b0) begin
      errors++;
      $display("FAIL short_cnt got %0d/%b want 2/0",
               bus.err_count, bus.pass);
    end
    set_len(16);
  endtask

  task automatic test_cfg_err();
    int n, te;
    int bad [2];
    bad[0] = 0;
    bad[1] = CL + 1;
    for (int j = 0; j < 2; j++) begin
      run(bad[j], -100, -1, -1, n, te);
      checks++;
      if (n !== 1 || te !== 0) begin
        errors++;
        $display("FAIL cfg_lat L=%0d got %0d/%0d want 1/0",
                 bad[j], n, te);
      end
      checks++;
      if (bus.cfg_err !== 1'b1 || bus.pass !== 1'b0) begin
        errors++;
        $display("FAIL cfg_flag L=%0d got %b/%b want 1/0",
                 bad[j], bus.cfg_err, bus.pass);
      end
    end
    @(negedge op_clk);
    checks++;
    if (bus.done !== 1'b0 || bus.cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_hold got %b/%b want 0/1",
               bus.done, bus.cfg_err);
    end
  endtask

  task automatic test_mid_reset();
    int n, te;
    set_len(32);
    stuck = 4'b0010;
    run(32, -100, -1, 43, n, te);
    checks++;
    if (bus.err_count !== 8'd10 || bus.err_mask !== 4'b0010) begin
      errors++;
      $display("FAIL mid_pre got %0d/%b want 10/0010",
               bus.err_count, bus.err_mask);
    end
    Reset = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.test_en !== 1'b0 ||
        bus.sc_head !== 4'b0) begin
      errors++;
      $display("FAIL mid_rst got %b/%b/%b want 0/0/0",
               bus.busy, bus.test_en, bus.sc_head);
    end
    checks++;
    if (bus.err_count !== 8'd0 || bus.err_mask !== 4'b0) begin
      errors++;
      $display("FAIL mid_clr got %0d/%b want 0/0",
               bus.err_count, bus.err_mask);
    end
    stuck = '0;
    @(negedge op_clk);
    Reset = 1'b1;
    run(32, -100, -1, -1, n, te);
    checks++;
    if (n !== 68 || bus.pass !== 1'b1) begin
      errors++;
      $display("FAIL mid_rerun got %0d/%b want 68/1", n, bus.pass);
    end
  endtask

  task automatic test_saturate();
    int n, te;
    set_len(CL);
    stuck = 4'b0001;
    run(CL, -100, -1, -1, n, te);
    checks++;
    if (n !== 516 || bus.cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL sat_lat got %0d/%b want 516/0", n, bus.cfg_err);
    end
    checks++;
    if (bus.err_count !== 8'd255 || bus.err_mask !== 4'b0001) begin
      errors++;
      $display("FAIL sat_cnt got %0d/%b want 255/0001",
               bus.err_count, bus.err_mask);
    end
    stuck = '0;
    set_len(16);
  endtask

  task automatic test_back_to_back();
    int n, te;
    set_len(8);
    run(8, -100, 3, -1, n, te);
    checks++;
    if (n !== 20 || bus.pass !== 1'b1) begin
      errors++;
      $display("FAIL b2b_flush got %0d/%b want 20/1", n, bus.pass);
    end
    flen[1] = 7;
    run(8, -100, 20, -1, n, te);
    checks++;
    if (bus.err_mask !== 4'b0010 || bus.err_count !== 8'd2) begin
      errors++;
      $display("FAIL b2b_fail got %b/%0d want 0010/2",
               bus.err_mask, bus.err_count);
    end
    @(negedge op_clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.err_mask !== 4'b0010) begin
      errors++;
      $display("FAIL b2b_done_ign got %b/%b want 0/0010",
               bus.busy, bus.err_mask);
    end
    flen[1] = 8;
    run(8, -100, -1, -1, n, te);
    checks++;
    if (bus.err_mask !== 4'b0 || bus.err_count !== 8'd0 ||
        bus.pass !== 1'b1) begin
      errors++;
      $display("FAIL b2b_clear got %b/%0d/%b want 0/0/1",
               bus.err_mask, bus.err_count, bus.pass);
    end
  endtask

`ifdef SCFF_BIST_PRBS_EN
  task automatic test_prbs();
    int n, te;
    set_len(64);
    bus.mode_prbs = 1'b1;
    run(64, -100, -1, -1, n, te);
    checks++;
    if (bus.pass !== 1'b1 || bus.err_count !== 8'd0) begin
      errors++;
      $display("FAIL prbs_pass got %b/%0d want 1/0",
               bus.pass, bus.err_count);
    end
    run(64, 65, -1, -1, n, te);
    checks++;
    if (bus.err_count !== 8'd1 || bus.err_mask !== 4'b0001) begin
      errors++;
      $display("FAIL prbs_flip got %0d/%b want 1/0001",
               bus.err_count, bus.err_mask);
    end
    bus.mode_prbs = 1'b0;
    set_len(16);
  endtask
`endif

  initial begin
    bus.start     = 1'b0;
    bus.chain_len = '0;
    bus.mode_prbs = 1'b0;
    stuck         = '0;
    flip          = '0;
    for (int i = 0; i < NC; i++) sr[i] = '1;
    set_len(16);
    repeat (3) @(negedge op_clk);
    test_reset();
    Reset = 1'b1;
    @(negedge op_clk);
    test_reset();
    test_pulse_pass();
    test_short_chain();
    test_cfg_err();
    test_mid_reset();
    test_saturate();
    test_back_to_back();
`ifdef SCFF_BIST_PRBS_EN
    test_prbs();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
